// File: rtl/hm_clock_counter.sv
// hm_clock_counter: 24-hour BCD timekeeper with a one-second prescaler and a
// three-state set FSM (RUN -> SET_HOUR -> SET_MIN -> RUN) for editing the time.
// Hour, minute and second are held directly in BCD so the display path needs
// no conversion; every output is a register.
module hm_clock_counter #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       mode_i,
    input  logic       inc_i,
    input  logic       show_min_i,
    output logic [7:0] hour_o,
    output logic [7:0] minute_o,
    output logic [7:0] second_o,
    output logic [1:0] state_o,
    output logic       disp_sel_o
);

    localparam int unsigned PresW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PresW-1:0] PresMax = PresW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StSetHour = 2'b01,
        StSetMin  = 2'b10,
        StBad     = 2'b11
    } state_e;

    state_e           state_q;
    logic [PresW-1:0] pres_q;
    logic [7:0]       hour_q;
    logic [7:0]       minute_q;
    logic [7:0]       second_q;
    logic             disp_sel_q;
    logic             sec_tick;

    // BCD +1 modulo 60; a units digit of 9 (or anything above) always carries,
    // so a units nibble can never reach 4'hA.
    function automatic logic [7:0] bcd_inc60(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h59) begin
            r = 8'h00;
        end else if (v[3:0] >= 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // BCD +1 modulo 24.
    function automatic logic [7:0] bcd_inc24(input logic [7:0] v);
        logic [7:0] r;
        if (v >= 8'h23) begin
            r = 8'h00;
        end else if (v[3:0] >= 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // One-second strobe: last prescaler count while running.
    always_comb begin
        sec_tick = (state_q == StRun) && (pres_q == PresMax);
    end

    // Prescaler, time registers, set FSM and display select in one registered block.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StRun;
            pres_q     <= '0;
            hour_q     <= 8'h00;
            minute_q   <= 8'h00;
            second_q   <= 8'h00;
            disp_sel_q <= 1'b0;
        end else begin
            // Prescaler only runs in RUN; any other state pins it at zero.
            if (state_q == StRun) begin
                pres_q <= sec_tick ? '0 : pres_q + 1'b1;
            end else begin
                pres_q <= '0;
            end

            // Full carry chain resolves in one edge (23:59:59 -> 00:00:00).
            if (sec_tick) begin
                second_q <= bcd_inc60(second_q);
                if (second_q == 8'h59) begin
                    minute_q <= bcd_inc60(minute_q);
                    if (minute_q == 8'h59) begin
                        hour_q <= bcd_inc24(hour_q);
                    end
                end
            end

            // mode has priority over inc; inc only edits in the set states.
            case (state_q)
                StRun: begin
                    if (mode_i) begin
                        state_q    <= StSetHour;
                        disp_sel_q <= 1'b0;
                    end else begin
                        disp_sel_q <= show_min_i;
                    end
                end
                StSetHour: begin
                    disp_sel_q <= 1'b0;
                    if (mode_i) begin
                        state_q    <= StSetMin;
                        disp_sel_q <= 1'b1;
                    end else if (inc_i) begin
                        hour_q <= bcd_inc24(hour_q);
                    end
                end
                StSetMin: begin
                    disp_sel_q <= 1'b1;
                    if (mode_i) begin
                        // Leaving edit restarts the second from a clean boundary.
                        state_q    <= StRun;
                        second_q   <= 8'h00;
                        pres_q     <= '0;
                        disp_sel_q <= show_min_i;
                    end else if (inc_i) begin
                        minute_q <= bcd_inc60(minute_q);
                    end
                end
                default: begin
                    // Unused encoding: recover to RUN without touching the time.
                    state_q    <= StRun;
                    disp_sel_q <= show_min_i;
                end
            endcase
        end
    end

    assign hour_o     = hour_q;
    assign minute_o   = minute_q;
    assign second_o   = second_q;
    assign state_o    = state_q;
    assign disp_sel_o = disp_sel_q;

endmodule

// File: tb/tb_hm_clock_counter.sv
// Bench for hm_clock_counter: a driver issues directed and random per-cycle
// stimulus and pushes the expected outputs from a seconds-of-day model; a
// separate monitor pops and compares after every rising edge.
module tb_hm_clock_counter;

    localparam int unsigned T = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode = 1'b0;
    logic       inc = 1'b0;
    logic       show_min = 1'b0;
    logic [7:0] hour;
    logic [7:0] minute;
    logic [7:0] second;
    logic [1:0] state;
    logic       disp_sel;

    hm_clock_counter #(.TICKS_PER_SEC(T)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .mode_i     (mode),
        .inc_i      (inc),
        .show_min_i (show_min),
        .hour_o     (hour),
        .minute_o   (minute),
        .second_o   (second),
        .state_o    (state),
        .disp_sel_o (disp_sel)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s;
        logic [1:0] st;
        logic       ds;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: time as seconds since midnight, mode as 0/1/2.
    int m_t   = 0;
    int m_cnt = 0;
    int m_st  = 0;
    bit m_ds  = 1'b0;

    int n_total = 0;
    int n_pass  = 0;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after that edge.
    task automatic step(input bit r, input bit md, input bit in, input bit sm);
        int   hh;
        int   mm;
        int   ss;
        bit   tick;
        exp_t e;
        @(negedge clk);
        rst      = r;
        mode     = md;
        inc      = in;
        show_min = sm;
        if (r) begin
            m_t   = 0;
            m_cnt = 0;
            m_st  = 0;
            m_ds  = 1'b0;
        end else begin
            tick  = (m_st == 0) && (m_cnt == int'(T) - 1);
            m_cnt = (m_st == 0) ? (m_cnt + 1) % int'(T) : 0;
            if (tick) m_t = (m_t + 1) % 86400;
            hh = m_t / 3600;
            mm = (m_t / 60) % 60;
            ss = m_t % 60;
            if (md) begin
                if (m_st == 0) begin
                    m_st = 1;
                end else if (m_st == 1) begin
                    m_st = 2;
                end else begin
                    m_st  = 0;
                    ss    = 0;
                    m_cnt = 0;
                end
            end else if (in && m_st == 1) begin
                hh = (hh + 1) % 24;
            end else if (in && m_st == 2) begin
                mm = (mm + 1) % 60;
            end
            m_t  = hh * 3600 + mm * 60 + ss;
            m_ds = (m_st == 0) ? sm : (m_st == 2);
        end
        e.h  = to_bcd(m_t / 3600);
        e.m  = to_bcd((m_t / 60) % 60);
        e.s  = to_bcd(m_t % 60);
        e.st = 2'(m_st);
        e.ds = m_ds;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input bit sm);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, sm);
    endtask

    task automatic incs(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Monitor: compare every output after each edge that has a queued expectation.
    initial begin
        exp_t e;
        bit   bcd_ok;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("time", {8'h0, hour, minute, second}, {8'h0, e.h, e.m, e.s});
                check("state", 32'(state), 32'(e.st));
                check("disp_sel", 32'(disp_sel), 32'(e.ds));
                bcd_ok = (hour[3:0] < 4'hA) && (minute[3:0] < 4'hA) && (second[3:0] < 4'hA);
                check("bcd_digits", 32'(bcd_ok), 32'd1);
            end
        end
    end

    // Driver: directed scenarios first, then random traffic.
    initial begin
        int guard;
        // Reset, first second lands on the 4th edge.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0);
        // Hour edit wraps 23 -> 00; minute edit wraps 59 -> 00; exit with show_min=1.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        incs(24);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        incs(60);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        idle(3, 1'b1);
        // Preload 23:59, run one minute across midnight.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        incs(23);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        incs(59);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(240, 1'b0);
        // mode+inc together in SET_MIN; inc alone in RUN.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        incs(7);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b0);
        // Reset in the middle of an hour edit, then toggle show_min.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        incs(15);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        idle(2, 1'b1);
        idle(2, 1'b0);
        idle(1, 1'b1);
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(199) == 0, $urandom_range(29) == 0,
                 $urandom_range(4) == 0, 1'($urandom_range(1)));
        end
        idle(2, 1'b0);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            #2;
            guard++;
        end
        if (exp_q.size() > 0) check("drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hm_clock_counter.md
# hm_clock_counter

Timekeeping stage that generates the BCD hour and minute bytes feeding the downstream 8-bit hour/minute display selector. It holds a 24-hour time (hour, minute, second), advances it from a clock-derived one-second prescaler, and provides a three-state set FSM so the user can edit hours and minutes with two pre-debounced pulse inputs. Its `hour` output drives the selector's `a` input, its `minute` output drives `b`, and its `disp_sel` output drives `sel`.

## Interface

- `TICKS_PER_SEC`, default 50_000_000: clk cycles per second (≥2); the bench overrides it to 4.
- `clk` input 1: system clock, rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `mode` input 1: single-cycle pulse, already debounced; advances the set FSM.
- `inc` input 1: single-cycle pulse, already debounced; increments the field being edited.
- `show_min` input 1: in RUN, selects the displayed field (0 = hour, 1 = minute).
- `hour` output 8: BCD 00–23 as {tens[7:4], units[3:0]}.
- `minute` output 8: BCD 00–59.
- `second` output 8: BCD 00–59.
- `state` output 2: RUN = 2'b00, SET_HOUR = 2'b01, SET_MIN = 2'b10.
- `disp_sel` output 1: select for the downstream mux (0 = hour, 1 = minute).

## Operation

- All outputs are registered. Reset values: hour 8'h00, minute 8'h00, second 8'h00, state RUN, disp_sel 0. The internal prescaler resets to 0.
- Prescaler behaviour:
  - Counts 0 to TICKS_PER_SEC-1 and wraps, only while in RUN.
  - `sec_tick` is asserted when prescaler == TICKS_PER_SEC-1 and state == RUN.
  - In SET_HOUR and SET_MIN the prescaler is held at 0.
- RUN, on `sec_tick`:
  - second increments in BCD: units 9 rolls to 0 with a tens carry, and 59 rolls to 00 with a minute carry.
  - minute follows the same rule; 59 rolls to 00 with an hour carry.
  - hour 23 rolls to 00; units roll 9→0 with a tens carry below 23.
  - All carries resolve in the same edge, e.g. 23:59:59 → 00:00:00 in one cycle.
- FSM transitions on `mode`: RUN → SET_HOUR → SET_MIN → RUN.
  - Entering SET_HOUR freezes the time.
  - The SET_MIN → RUN transition clears second to 00 and the prescaler to 0.
  - Illegal encoding 2'b11 returns to RUN on the next edge with time unchanged.
- `inc` behaviour:
  - In SET_HOUR, hour +1 in BCD, wrapping 23 → 00, with no effect on minute.
  - In SET_MIN, minute +1, wrapping 59 → 00, with no carry into hour.
  - In RUN, `inc` is ignored.
- If `mode` and `inc` are high in the same cycle, `mode` wins and `inc` is dropped.
- `disp_sel` is registered. It is 0 in SET_HOUR, 1 in SET_MIN, and equals `show_min` (sampled) in RUN. It updates on the same edge as `state`.
- BCD digits never leave 0–9. No binary value ≥ 8'h0A ever appears in a units nibble.

## Timing

- Output latency is one edge for all inputs: `mode`, `inc`, and `show_min` sampled at edge k are reflected in the outputs after edge k.
- After `rst` is deasserted, the first second increment lands on the TICKS_PER_SEC-th rising edge with `rst` low in RUN. Successive increments then occur exactly every TICKS_PER_SEC edges.
- Reset asserted mid-count or mid-edit forces all reset values at the next edge; `mode` and `inc` in that cycle are ignored.
- A `sec_tick` that coincides with `mode` in RUN applies both: time advances and state moves to SET_HOUR on the same edge.
- After returning to RUN, the next `sec_tick` is TICKS_PER_SEC edges later.

## Test plan

All scenarios use TICKS_PER_SEC = 4.

- Reset, then 4 edges with no inputs → second = 8'h01 after edge 4; hour and minute stay 8'h00; state = 2'b00.
- Preload via the set FSM to 23:59, return to RUN, then run 240 edges → time reads 00:00:00 with hour = 8'h00 and minute = 8'h00; second passes through 8'h09 → 8'h10 (never 8'h0A).
- mode; inc ×24 → hour = 8'h00 after wrapping through 8'h09 → 8'h10 and 8'h23 → 8'h00; minute is unchanged; disp_sel = 0.
- mode ×2; inc ×60 → minute = 8'h00 with hour unchanged; one more mode → state 2'b00, second = 8'h00, disp_sel = show_min.
- In SET_MIN, assert `mode` and `inc` together → state = RUN and minute unchanged. In RUN, `inc` alone → no change.
- In SET_HOUR at hour 8'h15, assert `rst` for 1 cycle → all outputs 0 and state RUN. In RUN, toggle `show_min` → disp_sel follows one edge later.
